trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Initiator side of the machine-mode CSR file's trap-update interface.
- Takes synchronous exceptions from the pipeline, pending machine interrupts and MRET requests, and arbitrates among them.
- Drives the CSR file's single-port trap writes (mepc, mcause, mtval, mstatus) one per cycle, because the CSR file accepts only one of them per cycle.
- Then issues a PC redirect to the trap vector or to mepc.

Parameters:
- RESET_PC, 32'h0000_0000, redirect_pc value held while idle/after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- exc_valid  in  1  pipeline reports a synchronous exception this cycle
- exc_code  in  5  exception cause code
- exc_pc  in  32  PC of faulting instruction
- exc_tval  in  32  trap value (bad address/instruction)
- mret_req  in  1  MRET committing this cycle
- irq_pc  in  32  PC of next instruction to execute (interrupt return point)
- inst_boundary  in  1  pipeline is at a clean boundary, interrupt may be taken
- meip  in  1  external interrupt pending
- mtip  in  1  timer interrupt pending
- meie  in  1  mie.MEIE
- mtie  in  1  mie.MTIE
- mstatus_mie  in  1  global machine interrupt enable from the CSR file
- mtvec  in  32  mtvec CSR value
- mepc  in  32  mepc CSR value
- mepc_we  out  1  write strobe for mepc
- mepc_d  out  32  mepc write data
- mcause_we  out  1  write strobe for mcause
- mcause_iore  out  1  1 = interrupt, 0 = exception
- mcause_d_e  out  5  cause code
- mtval_we  out  1  write strobe for mtval
- mtval_d  out  32  mtval write data
- mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
- mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1
- stall  out  1  pipeline must hold
- redirect_valid  out  1  one-cycle pulse, fetch from redirect_pc
- redirect_pc  out  32  target PC

Behaviour:
- Reset (async): state=IDLE; all strobes, stall and redirect_valid 0; redirect_pc=RESET_PC; latched cause/epc/tval cleared.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIR, MRET.
- Requests are sampled only in IDLE. Priority, highest first:
  - exc_valid
  - external interrupt (meip&meie&mstatus_mie&inst_boundary), code 11
  - timer interrupt (mtip&mtie&mstatus_mie&inst_boundary), code 7
  - mret_req
- A lower-priority request arriving in the same cycle is dropped; the pipeline reissues it.
- Trap accept (IDLE, cycle 0):
  - Latch iore, code, epc, tval:
    - exception: epc=exc_pc, tval=exc_tval
    - interrupt: epc=irq_pc, tval=0
  - stall=1 combinationally this cycle; go to W_EPC.
- W_EPC: mepc_we=1, mepc_d={epc[31:2],2'b00}. Go to W_CAUSE.
- W_CAUSE: mcause_we=1, mcause_iore and mcause_d_e from the latch; mstatus_trap=1. Go to W_TVAL.
- W_TVAL: mtval_we=1, mtval_d=tval. Go to REDIR.
- REDIR: redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}. Go to IDLE.
- Trap latency: redirect 4 cycles after accept. stall=1 from the accept cycle through REDIR inclusive.
- MRET accept: stall=1; next cycle state MRET: mstatus_mret=1, redirect_valid=1, redirect_pc={mepc[31:2],2'b00}. Then IDLE.
- Exactly one CSR write strobe is active in any cycle. Strobes are never asserted in IDLE.
- Interrupt lines are level inputs. A pending line that deasserts after accept does not abort the sequence.
- mstatus_mie=0 masks all interrupts regardless of meie/mtie. Exceptions are never masked.
- Async reset mid-sequence aborts immediately: no further strobes or redirect. CSR writes already performed remain.
- redirect_pc holds its last value outside REDIR/MRET.

Optional Feature:
- VECTORED_MTVEC_EN
- Defined: when mtvec[1:0]==2'b01 and the trap is an interrupt, REDIR target = {mtvec[31:2],2'b00} + 4*code. Exceptions always go to the base.
- Undefined: mtvec[1:0] is ignored and all traps go to the base.

Test Plan:
- Exception: exc_valid, code 11, exc_pc 0x100, mtvec 0x8000_0000 -> mepc_we(d=0x100), then mcause_we(iore=0, code=11)+mstatus_trap, then mtval_we, then redirect 0x8000_0000; stall high 5 cycles.
- Timer interrupt: mtip=mtie=mstatus_mie=inst_boundary=1, irq_pc 0x204 -> mepc_d=0x204, iore=1, code 7, mtval_d=0. With mstatus_mie=0 -> no strobes, stall stays 0.
- Simultaneous exc_valid+meip+mret_req -> exception sequence only; no mstatus_mret.
- MRET with mepc 0x0000_0404 -> mstatus_mret and redirect_valid together one cycle later; redirect_pc 0x404.
- Assert rst during W_CAUSE -> outputs 0 at once; no mtval_we or redirect afterwards.
- VECTORED_MTVEC_EN, mtvec 0x1001, MEI -> redirect 0x102C; exception with the same mtvec -> redirect 0x1000.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET, then
// drives mepc/mcause/mtval writes one per cycle and a PC redirect. Optional: VECTORED_MTVEC_EN.
module trap_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic [31:0] irq_pc,
  input  logic        inst_boundary,
  input  logic        meip,
  input  logic        mtip,
  input  logic        meie,
  input  logic        mtie,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        mepc_we,
  output logic [31:0] mepc_d,
  output logic        mcause_we,
  output logic        mcause_iore,
  output logic [4:0]  mcause_d_e,
  output logic        mtval_we,
  output logic [31:0] mtval_d,
  output logic        mstatus_trap,
  output logic        mstatus_mret,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_TVAL  = 3'd3,
    REDIR   = 3'd4,
    MRET    = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_iore;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic [31:0] r_tval;
  logic        r_mepc_we;
  logic        r_mcause_we;
  logic        r_mtval_we;
  logic        r_mstatus_trap;
  logic        r_mstatus_mret;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic        w_idle;
  logic        w_ext_pend;
  logic        w_tmr_pend;
  logic        w_take_exc;
  logic        w_take_ext;
  logic        w_take_tmr;
  logic        w_take_mret;
  logic        w_take_trap;
  logic        w_new_iore;
  logic [4:0]  w_new_code;
  logic [31:0] w_new_epc;
  logic [31:0] w_new_tval;
  logic [31:0] w_base;
  logic [31:0] w_trap_target;
  logic        w_unused_bits;

  assign w_idle      = (r_state == IDLE);
  assign w_ext_pend  = meip & meie & mstatus_mie & inst_boundary;
  assign w_tmr_pend  = mtip & mtie & mstatus_mie & inst_boundary;

  // Fixed priority: exception > external > timer > mret; losers are dropped.
  assign w_take_exc  = w_idle & exc_valid;
  assign w_take_ext  = w_idle & ~exc_valid & w_ext_pend;
  assign w_take_tmr  = w_idle & ~exc_valid & ~w_ext_pend & w_tmr_pend;
  assign w_take_mret = w_idle & ~exc_valid & ~w_ext_pend & ~w_tmr_pend & mret_req;
  assign w_take_trap = w_take_exc | w_take_ext | w_take_tmr;

  always_comb begin
    w_new_iore = 1'b0;
    w_new_code = exc_code;
    w_new_epc  = exc_pc;
    w_new_tval = exc_tval;
    if (!exc_valid) begin
      w_new_iore = 1'b1;
      w_new_code = w_ext_pend ? 5'd11 : 5'd7;
      w_new_epc  = irq_pc;
      w_new_tval = '0;
    end
  end

  assign w_base = {mtvec[31:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
  assign w_trap_target = (mtvec[1:0] == 2'b01 && r_iore) ?
                         (w_base + {25'b0, r_code, 2'b00}) : w_base;
`else
  assign w_trap_target = w_base;
`endif

  assign w_unused_bits = ^{mtvec[1:0], mepc[1:0], r_epc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_iore           <= 1'b0;
      r_code           <= '0;
      r_epc            <= '0;
      r_tval           <= '0;
      r_mepc_we        <= 1'b0;
      r_mcause_we      <= 1'b0;
      r_mtval_we       <= 1'b0;
      r_mstatus_trap   <= 1'b0;
      r_mstatus_mret   <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= RESET_PC;
    end else begin
      r_mepc_we        <= 1'b0;
      r_mcause_we      <= 1'b0;
      r_mtval_we       <= 1'b0;
      r_mstatus_trap   <= 1'b0;
      r_mstatus_mret   <= 1'b0;
      r_redirect_valid <= 1'b0;
      // Outputs are registered, so each state's strobes are set on entry.
      case (r_state)
        IDLE: begin
          if (w_take_trap) begin
            r_iore    <= w_new_iore;
            r_code    <= w_new_code;
            r_epc     <= w_new_epc;
            r_tval    <= w_new_tval;
            r_mepc_we <= 1'b1;
            r_state   <= W_EPC;
          end else if (w_take_mret) begin
            r_mstatus_mret   <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= {mepc[31:2], 2'b00};
            r_state          <= MRET;
          end
        end
        W_EPC: begin
          r_mcause_we    <= 1'b1;
          r_mstatus_trap <= 1'b1;
          r_state        <= W_CAUSE;
        end
        W_CAUSE: begin
          r_mtval_we <= 1'b1;
          r_state    <= W_TVAL;
        end
        W_TVAL: begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_trap_target;
          r_state          <= REDIR;
        end
        REDIR:   r_state <= IDLE;
        MRET:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mepc_we        = r_mepc_we;
  assign mepc_d         = {r_epc[31:2], 2'b00};
  assign mcause_we      = r_mcause_we;
  assign mcause_iore    = r_iore;
  assign mcause_d_e     = r_code;
  assign mtval_we       = r_mtval_we;
  assign mtval_d        = r_tval;
  assign mstatus_trap   = r_mstatus_trap;
  assign mstatus_mret   = r_mstatus_mret;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign stall          = ~w_idle | w_take_trap | w_take_mret;

endmodule
